// File: rtl/me_pkg.sv
// Shared constants for the motion-estimation datapath (ctrl, AD_ARRAY, MIN_16).
package me_pkg;

   localparam int SAD_W    = 14;
   localparam int EDGE_LEN = 8;

   // 3-bit state encoding for the search sequencer
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_FILL   = 3'd2;
   localparam logic [2:0] ST_SEARCH = 3'd3;
   localparam logic [2:0] ST_DRAIN  = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_LOAD   = ST_LOAD,
      S_FILL   = ST_FILL,
      S_SEARCH = ST_SEARCH,
      S_DRAIN  = ST_DRAIN,
      S_DONE   = ST_DONE
   } me_state_e;

endpackage

// File: rtl/me_tag_pipe.sv
// Delay line carrying {valid, col} alongside the AD_ARRAY/MIN_16 latency so the
// batch minimum can be matched to the column that produced it.
module me_tag_pipe #(
   parameter int PIPE_LAT = 2,
   parameter int X_W      = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_vld,
   input  logic [X_W-1:0] in_col,
   output logic           out_vld,
   output logic [X_W-1:0] out_col
);

   logic [PIPE_LAT:1]          vld_pipe;
   logic [PIPE_LAT:1][X_W-1:0] col_pipe;

   // shift every cycle; stalls enter as valid=0 bubbles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         col_pipe <= '0;
      end else begin
         vld_pipe[1] <= in_vld;
         col_pipe[1] <= in_col;
         for (int s = 2; s <= PIPE_LAT; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            col_pipe[s] <= col_pipe[s-1];
         end
      end
   end

   assign out_vld = vld_pipe[PIPE_LAT];
   assign out_col = col_pipe[PIPE_LAT];

endmodule

// File: rtl/me_search_ctrl.sv
// Sequencer for one current-block motion search: load block, pre-fill the
// reference window, sweep N_COLS columns, track the running SAD minimum and
// hand the winner out over valid/ready.
module me_search_ctrl #(
   parameter int SAD_W        = me_pkg::SAD_W,
   parameter int EDGE_LEN     = me_pkg::EDGE_LEN,
   parameter int CUR_LOAD_CYC = 16,
   parameter int N_COLS       = 32,
   parameter int PIPE_LAT     = 2,
   parameter int X_W          = $clog2(N_COLS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sram_ready,
   input  logic [SAD_W-1:0] msad,
   input  logic [3:0]       msad_idx,
   output logic             cur_load,
   output logic             cur_next_block,
   output logic             col_adv,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [SAD_W-1:0] res_sad,
   output logic [X_W-1:0]   res_mv_x,
   output logic [3:0]       res_mv_y
);
   import me_pkg::*;

   // one shared counter serves LOAD (down), FILL (up) and DRAIN (down)
   localparam int CNT_W = $clog2(CUR_LOAD_CYC + EDGE_LEN + PIPE_LAT);
   localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(CUR_LOAD_CYC - 1);
   localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(EDGE_LEN - 2);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_LAT - 1);
   localparam logic [X_W-1:0]   COL_LAST   = X_W'(N_COLS - 1);

   me_state_e        state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [X_W-1:0]   col;
   logic             tag_vld;
   logic [X_W-1:0]   tag_col;
   logic [SAD_W-1:0] best_sad;
   logic [X_W-1:0]   best_x;
   logic [3:0]       best_y;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // next-state and per-state strobes
   always_comb begin
      state_nx       = state;
      cur_load       = 1'b0;
      cur_next_block = 1'b0;
      col_adv        = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               cur_next_block = 1'b1;
               state_nx       = S_LOAD;
            end
         end
         S_LOAD: begin
            cur_load = 1'b1;
            if (cnt == '0) state_nx = S_FILL;
         end
         S_FILL: begin
            col_adv = sram_ready;
            if (sram_ready && cnt == FILL_LAST) state_nx = S_SEARCH;
         end
         S_SEARCH: begin
            col_adv = sram_ready;
            if (sram_ready && col == COL_LAST) state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            if (cnt == '0) state_nx = S_DONE;
         end
         S_DONE: begin
            if (res_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign busy      = (state != S_IDLE);
   assign res_valid = (state == S_DONE);

   // phase counter and search column
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         col <= '0;
      end else begin
         case (state)
            S_IDLE:  if (start) cnt <= LOAD_LAST;
            S_LOAD:  if (cnt != '0) cnt <= cnt - 1'b1;
            S_FILL: begin
               col <= '0;
               if (col_adv) cnt <= (cnt == FILL_LAST) ? '0 : cnt + 1'b1;
            end
            S_SEARCH: begin
               if (col_adv) begin
                  if (col == COL_LAST) begin
                     col <= '0;
                     cnt <= DRAIN_LAST;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            S_DRAIN: if (cnt != '0) cnt <= cnt - 1'b1;
            default: ;
         endcase
      end
   end

   // only SEARCH advances are real candidates; everything else is a bubble
   me_tag_pipe #(
      .PIPE_LAT (PIPE_LAT),
      .X_W      (X_W)
   ) u_tag_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (col_adv && state == S_SEARCH),
      .in_col  (col),
      .out_vld (tag_vld),
      .out_col (tag_col)
   );

   // running minimum; strict compare keeps the earliest column on ties
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best_sad <= '1;
         best_x   <= '0;
         best_y   <= '0;
      end else if (state == S_FILL && state_nx == S_SEARCH) begin
         best_sad <= '1;
      end else if (tag_vld && msad < best_sad) begin
         best_sad <= msad;
         best_x   <= tag_col;
         best_y   <= msad_idx;
      end
   end

   assign res_sad  = best_sad;
   assign res_mv_x = best_x;
   assign res_mv_y = best_y;

endmodule

// File: tb/tb_me_search_ctrl.sv
// Directed bench for me_search_ctrl: table of full-search runs plus reset cases.
module tb_me_search_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        sram_ready = 1'b1;
   logic [13:0] msad = '0;
   logic [3:0]  msad_idx = '0;
   logic        res_ready = 1'b1;
   logic        cur_load, cur_next_block, col_adv, busy, res_valid;
   logic [13:0] res_sad;
   logic [4:0]  res_mv_x;
   logic [3:0]  res_mv_y;

   me_search_ctrl #(
      .SAD_W(14), .EDGE_LEN(8), .CUR_LOAD_CYC(16), .N_COLS(32), .PIPE_LAT(2), .X_W(5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sram_ready(sram_ready),
      .msad(msad), .msad_idx(msad_idx), .cur_load(cur_load),
      .cur_next_block(cur_next_block), .col_adv(col_adv), .busy(busy),
      .res_valid(res_valid), .res_ready(res_ready), .res_sad(res_sad),
      .res_mv_x(res_mv_x), .res_mv_y(res_mv_y)
   );

   always #5 clk = ~clk;

   typedef struct {
      int mode;
      int fs_at, fs_n, ss_at, ss_n;
      int bp;
      int st_a, st_b, st_c;
      int exp_cyc, exp_sad, exp_x, exp_y;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // run context used by the per-cycle driver
   int cyc = 1000;
   int mode, fs_at, fs_n, ss_at, ss_n, bp, st_a, st_b, st_c;
   int done_cyc, adv_n, ld_n, cnb_n;
   logic d1_v, d2_v;
   int d1_c, d2_c;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // reference MIN_16 output for a search column
   function automatic void model(input int m, input int c,
                                 output logic [13:0] s, output logic [3:0] ix);
      ix = 4'(c % 16);
      s  = 14'd100;
      case (m)
         0: if (c == 13) begin s = 14'd40; ix = 4'd5; end
         1: begin
            if (c == 4)      begin s = 14'd20; ix = 4'd2; end
            else if (c == 9) begin s = 14'd20; ix = 4'd7; end
         end
         2: s = 14'(500 - 10 * c);
         3: if (c == 0) begin s = 14'd0; ix = 4'd9; end
         default: ;
      endcase
   endfunction

   // drive this cycle's inputs just after the rising edge
   task automatic begin_cycle();
      logic [13:0] s;
      logic [3:0]  ix;
      @(posedge clk);
      #1;
      cyc++;
      sram_ready = !((cyc >= fs_at && cyc < fs_at + fs_n) ||
                     (cyc >= ss_at && cyc < ss_at + ss_n));
      start      = (cyc == 0) || (cyc == st_a) || (cyc == st_b) || (cyc == st_c);
      res_ready  = (bp == 0) || (done_cyc >= 0 && cyc >= done_cyc + bp);
      if (d2_v) begin
         model(mode, d2_c, s, ix);
         msad = s; msad_idx = ix;
      end else begin
         msad = '0; msad_idx = '0;   // junk a correct design must ignore
      end
   endtask

   // sample outputs mid-cycle and advance the latency model
   task automatic end_cycle();
      logic tv;
      int   tc;
      @(negedge clk);
      if (cur_next_block) cnb_n++;
      if (cur_load) ld_n++;
      tv = col_adv && adv_n >= 7;
      tc = adv_n - 7;
      if (col_adv) adv_n++;
      d2_v = d1_v; d2_c = d1_c;
      d1_v = tv;   d1_c = tc;
      if (res_valid && done_cyc < 0) done_cyc = cyc;
   endtask

   task automatic setup(input vec_t v);
      mode = v.mode; fs_at = v.fs_at; fs_n = v.fs_n; ss_at = v.ss_at; ss_n = v.ss_n;
      bp = v.bp; st_a = v.st_a; st_b = v.st_b; st_c = v.st_c;
      done_cyc = -1; adv_n = 0; ld_n = 0; cnb_n = 0;
      d1_v = 1'b0; d2_v = 1'b0; d1_c = 0; d2_c = 0;
      cyc = -1;
   endtask

   task automatic run(input vec_t v, input int id);
      logic [24:0] exp_pk;
      setup(v);
      begin_cycle(); end_cycle();
      while (done_cyc < 0 && cyc < 400) begin
         begin_cycle(); end_cycle();
      end
      chk($sformatf("v%0d done_cycle", id), done_cyc, v.exp_cyc);
      chk($sformatf("v%0d res_sad", id), res_sad, v.exp_sad);
      chk($sformatf("v%0d res_mv_x", id), res_mv_x, v.exp_x);
      chk($sformatf("v%0d res_mv_y", id), res_mv_y, v.exp_y);
      exp_pk = {1'b1, 1'b1, 14'(v.exp_sad), 5'(v.exp_x), 4'(v.exp_y)};
      while (done_cyc >= 0 && cyc < done_cyc + bp) begin
         begin_cycle(); end_cycle();
         chk($sformatf("v%0d hold c%0d", id, cyc),
             {res_valid, busy, res_sad, res_mv_x, res_mv_y}, exp_pk);
      end
      begin_cycle(); end_cycle();
      chk($sformatf("v%0d idle_after busy", id), busy, 0);
      chk($sformatf("v%0d idle_after res_valid", id), res_valid, 0);
      chk($sformatf("v%0d col_adv count", id), adv_n, 39);
      chk($sformatf("v%0d cur_load count", id), ld_n, 16);
      chk($sformatf("v%0d cur_next_block count", id), cnb_n, 1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " cur_load"}, cur_load, 0);
      chk({tag, " cur_next_block"}, cur_next_block, 0);
      chk({tag, " col_adv"}, col_adv, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " res_valid"}, res_valid, 0);
      chk({tag, " res_sad"}, res_sad, 14'h3fff);
      chk({tag, " res_mv_x"}, res_mv_x, 0);
      chk({tag, " res_mv_y"}, res_mv_y, 0);
   endtask

   vec_t vecs[7];

   initial begin
      //           mode fsat fsn ssat ssn bp  sta stb stc  cyc sad x  y
      vecs[0] = '{0,   -1,  0,  -1,  0,  0,  -1, -1, -1,  58, 40,  13, 5};
      vecs[1] = '{1,   -1,  0,  -1,  0,  0,  -1, -1, -1,  58, 20,  4,  2};
      vecs[2] = '{2,   -1,  0,  -1,  0,  0,  -1, -1, -1,  58, 190, 31, 15};
      vecs[3] = '{3,   -1,  0,  -1,  0,  0,  -1, -1, -1,  58, 0,   0,  9};
      vecs[4] = '{0,   18,  3,  35,  5,  0,  -1, -1, -1,  66, 40,  13, 5};
      vecs[5] = '{1,   -1,  0,  -1,  0,  10, -1, -1, -1,  58, 20,  4,  2};
      vecs[6] = '{2,   -1,  0,  -1,  0,  0,  5,  40, 58,  58, 190, 31, 15};

      // power-on reset with sram_ready high: nothing may fire
      fs_at = -1; fs_n = 0; ss_at = -1; ss_n = 0; bp = 0;
      st_a = -1; st_b = -1; st_c = -1; done_cyc = -1;
      d1_v = 1'b0; d2_v = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("por");
      @(posedge clk); #1 rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run(vecs[i], i);

      // reset in the middle of SEARCH, right after column 10 advances
      setup(vecs[3]);
      begin_cycle(); end_cycle();
      while (adv_n < 18 && cyc < 200) begin
         begin_cycle(); end_cycle();
      end
      chk("midrst reached col10", adv_n, 18);
      chk("midrst best before reset", res_sad, 0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      sram_ready = 1'b1;
      start = 1'b0;
      #2;
      chk_reset_outputs("midrst");
      @(negedge clk);
      chk("midrst held busy", busy, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc = 1000;
      repeat (3) begin begin_cycle(); end_cycle(); end
      chk("midrst no spurious res_valid", res_valid, 0);
      run(vecs[0], 7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
